// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - raw key in, debounced level and busy flag out
interface key_debounce_if;
  logic key_i;
  logic key_o;
  logic busy_o;

  modport master (output key_i, input key_o, busy_o);
  modport slave  (input key_i, output key_o, busy_o);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer, press/release qualifier, optional auto-repeat
// Define KEY_AUTOREPEAT_EN to insert one-cycle low gaps while the key is held.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  key_debounce_if.slave key
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (longint'(DEBOUNCE_CYCLES) > CNT_MAX || longint'(HOLD_CYCLES) > CNT_MAX ||
      longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_cnt_w_too_narrow
    $error("key_debounce: CNT_W cannot hold the configured cycle counts");
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    DOWN      = 3'd2,
    REL_CHK   = 3'd3,
    GAP       = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    DOWN      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;
`endif

  logic             sync1;
  logic             key_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             key_nxt;
  logic             busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
    end else begin
      sync1 <= key.key_i;
      key_s <= sync1;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Selects the hold interval for the first gap after a fresh DOWN entry, the repeat interval afterwards.
  logic first;
  logic gap_due;

  assign gap_due = first ? (cnt == HOLD_LAST) : (cnt == REPEAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first <= 1'b1;
    end else if (state_nxt == GAP) begin
      first <= 1'b0;
    end else if (state_nxt == DOWN && state != DOWN && state != GAP) begin
      first <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_s) state_nxt = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!key_s)                state_nxt = IDLE;
        else if (cnt == DB_LAST)   state_nxt = DOWN;
      end
      DOWN: begin
        if (!key_s)                state_nxt = REL_CHK;
`ifdef KEY_AUTOREPEAT_EN
        else if (gap_due)          state_nxt = GAP;
`endif
      end
      REL_CHK: begin
        if (key_s)                 state_nxt = DOWN;
        else if (cnt == DB_LAST)   state_nxt = IDLE;
      end
`ifdef KEY_AUTOREPEAT_EN
      GAP: begin
        state_nxt = DOWN;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    key_nxt  = (state_nxt == DOWN) || (state_nxt == REL_CHK);
    busy_nxt = (state_nxt == PRESS_CHK) || (state_nxt == REL_CHK);
  end

  // Counter saturates rather than wraps so a long hold never aliases back to a compare value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      key.key_o  <= 1'b0;
      key.busy_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      key.key_o  <= key_nxt;
      key.busy_o <= busy_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
